// File: rtl/power_uart_pkg.sv
// power_uart_pkg
//   Shared definitions for the power-module UART responder: the UART FSM
//   state encoding used by both the receive and transmit paths, the default
//   bit timing for 50 MHz / 24000 baud, and the command/response frame lengths.
package power_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int BPS_PARA_DEF   = 2082;   // bit period minus one
  localparam int BPS_PARA_2_DEF = 1041;   // mid-bit sample offset
  localparam int WAIT_TIME_DEF  = 22916;  // inter-byte gap limit (~11 bit times)

  localparam int CMD_BYTES = 4;
  localparam int RSP_BYTES = 5;

endpackage

// File: rtl/power_baud_cnt.sv
// power_baud_cnt
//   Bit-period counter. Counts 0..BPS_PARA while enabled and is held at zero
//   while disabled, so each enable burst starts a fresh bit period.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   i_en   in   count enable (counter clears when low)
//   o_mid  out  mid-bit tick, count == BPS_PARA_2
//   o_end  out  end-of-bit tick, count == BPS_PARA
module power_baud_cnt #(
  parameter int BPS_PARA   = 2082,
  parameter int BPS_PARA_2 = 1041
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_mid,
  output logic o_end
);

  localparam int            CW    = $clog2(BPS_PARA + 1);
  localparam logic [CW-1:0] L_END = CW'(BPS_PARA);
  localparam logic [CW-1:0] L_MID = CW'(BPS_PARA_2);
  localparam logic [CW-1:0] L_ONE = CW'(1);

  logic [CW-1:0] r_cnt;

  // Bit-period counter: wraps at the end of each bit, clears when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == L_END) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + L_ONE;
    end
  end

  assign o_mid = i_en & (r_cnt == L_MID);
  assign o_end = i_en & (r_cnt == L_END);

endmodule

// File: rtl/power_uart_resp.sv
// power_uart_resp
//   Power-module end of the power amplifier UART command link.
//   RX: deserialises 4-byte host command frames (first byte in [31:24]) into
//       cmd_data with a one-cycle cmd_vld pulse; a stop-bit error pulses
//       frame_err and drops the partial frame; an over-long inter-byte gap
//       silently drops the partial frame.
//   TX: serialises a 40-bit response ([39:32] first) as 5 back-to-back bytes.
//   RX and TX run independently (full duplex). 8N1, LSB first.
// Ports:
//   clk        in   50 MHz system clock
//   rst_n      in   synchronous active-low reset
//   rs232_rx   in   serial line from host (idle high)
//   rs232_tx   out  serial line to host (idle high)
//   cmd_data   out  last complete command word
//   cmd_vld    out  one-cycle pulse when cmd_data updates
//   rsp_en     in   send request, honoured only while idle
//   rsp_data   in   40-bit response word
//   rsp_busy   out  high while a response frame is on the line
//   frame_err  out  one-cycle pulse on a stop-bit error
module power_uart_resp
  import power_uart_pkg::*;
#(
  parameter int BPS_PARA   = BPS_PARA_DEF,
  parameter int BPS_PARA_2 = BPS_PARA_2_DEF,
  parameter int WAIT_TIME  = WAIT_TIME_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rs232_rx,
  output logic        rs232_tx,
  output logic [31:0] cmd_data,
  output logic        cmd_vld,
  input  logic        rsp_en,
  input  logic [39:0] rsp_data,
  output logic        rsp_busy,
  output logic        frame_err
);

  localparam int            GW     = $clog2(WAIT_TIME + 1);
  localparam logic [GW-1:0] L_WAIT = GW'(WAIT_TIME);
  localparam logic [GW-1:0] L_GONE = GW'(1);

  // ---------------------------------------------------------------- RX path
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  logic        w_rx_fall;
  uart_state_e r_rx_state, w_rx_state_nxt;
  logic        w_rx_mid, w_rx_end_unused;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_byte;
  logic        w_byte_ok, w_stop_bad;
  logic [1:0]  r_rx_idx;
  logic [23:0] r_rx_shift;
  logic [GW-1:0] r_gap;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rs232_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  power_baud_cnt #(
    .BPS_PARA   (BPS_PARA),
    .BPS_PARA_2 (BPS_PARA_2)
  ) u_rx_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_rx_state != ST_IDLE),
    .o_mid (w_rx_mid),
    .o_end (w_rx_end_unused)
  );

  // RX state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= ST_IDLE;
    end else begin
      r_rx_state <= w_rx_state_nxt;
    end
  end

  // RX next state; the counter keeps running from START into DATA so every
  // mid tick lands in the middle of the following bit.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_byte_ok      = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        if (w_rx_fall) w_rx_state_nxt = ST_START;
        else           w_rx_state_nxt = ST_IDLE;
      end
      ST_START: begin
        // line back high at mid-start means a glitch: drop it quietly
        if (w_rx_mid) w_rx_state_nxt = r_rx_s2 ? ST_IDLE : ST_DATA;
        else          w_rx_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_rx_mid && (r_rx_bit == 3'd7)) w_rx_state_nxt = ST_STOP;
        else                                w_rx_state_nxt = ST_DATA;
      end
      ST_STOP: begin
        if (w_rx_mid) begin
          w_rx_state_nxt = ST_IDLE;
          if (r_rx_s2) w_byte_ok  = 1'b1;
          else         w_stop_bad = 1'b1;
        end else begin
          w_rx_state_nxt = ST_STOP;
        end
      end
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  // RX bit counter and LSB-first data shifter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_bit  <= 3'd0;
      r_rx_byte <= 8'h00;
    end else if ((r_rx_state == ST_DATA) && w_rx_mid) begin
      r_rx_bit  <= r_rx_bit + 3'd1;
      r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
    end else if (r_rx_state != ST_DATA) begin
      r_rx_bit  <= 3'd0;
      r_rx_byte <= r_rx_byte;
    end else begin
      r_rx_bit  <= r_rx_bit;
      r_rx_byte <= r_rx_byte;
    end
  end

  // Command frame assembly, stop-bit error reporting and inter-byte gap timer.
  // Only three bytes are buffered; the fourth goes straight into cmd_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_idx   <= 2'd0;
      r_rx_shift <= 24'h000000;
      r_gap      <= '0;
      cmd_data   <= 32'h00000000;
      cmd_vld    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_vld   <= 1'b0;
      frame_err <= w_stop_bad;
      if (w_byte_ok) begin
        r_gap <= '0;
        if (r_rx_idx == 2'(CMD_BYTES - 1)) begin
          cmd_data <= {r_rx_shift, r_rx_byte};
          cmd_vld  <= 1'b1;
          r_rx_idx <= 2'd0;
        end else begin
          r_rx_shift <= {r_rx_shift[15:0], r_rx_byte};
          r_rx_idx   <= r_rx_idx + 2'd1;
        end
      end else if (w_stop_bad) begin
        r_rx_idx <= 2'd0;
        r_gap    <= '0;
      end else if ((r_rx_idx != 2'd0) && (r_rx_state == ST_IDLE)) begin
        if (r_gap == L_WAIT) begin
          r_rx_idx <= 2'd0;
          r_gap    <= '0;
        end else begin
          r_gap <= r_gap + L_GONE;
        end
      end else if (r_rx_idx == 2'd0) begin
        r_gap <= '0;
      end else begin
        r_gap <= r_gap;
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  uart_state_e r_tx_state, w_tx_state_nxt;
  logic        w_tx_mid_unused, w_tx_end;
  logic        w_tx_load, w_tx_next_byte;
  logic [39:0] r_tx_data;
  logic [7:0]  w_tx_cur;
  logic [2:0]  r_tx_idx;
  logic [2:0]  r_tx_bit;

  power_baud_cnt #(
    .BPS_PARA   (BPS_PARA),
    .BPS_PARA_2 (BPS_PARA_2)
  ) u_tx_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_tx_state != ST_IDLE),
    .o_mid (w_tx_mid_unused),
    .o_end (w_tx_end)
  );

  assign w_tx_cur = r_tx_data[39:32];

  // TX state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nxt;
    end
  end

  // TX next state; bytes follow each other with no idle gap.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_load      = 1'b0;
    w_tx_next_byte = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        if (rsp_en) begin
          w_tx_state_nxt = ST_START;
          w_tx_load      = 1'b1;
        end else begin
          w_tx_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tx_end) w_tx_state_nxt = ST_DATA;
        else          w_tx_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_tx_end && (r_tx_bit == 3'd7)) w_tx_state_nxt = ST_STOP;
        else                                w_tx_state_nxt = ST_DATA;
      end
      ST_STOP: begin
        if (w_tx_end) begin
          if (r_tx_idx < 3'(RSP_BYTES - 1)) begin
            w_tx_state_nxt = ST_START;
            w_tx_next_byte = 1'b1;
          end else begin
            w_tx_state_nxt = ST_IDLE;
          end
        end else begin
          w_tx_state_nxt = ST_STOP;
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
  end

  // TX response latch, byte index and bit index. The response is captured
  // once on acceptance so later rsp_data changes cannot leak onto the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_data <= 40'h0000000000;
      r_tx_idx  <= 3'd0;
      r_tx_bit  <= 3'd0;
    end else begin
      if (w_tx_load) begin
        r_tx_data <= rsp_data;
        r_tx_idx  <= 3'd0;
      end else if (w_tx_next_byte) begin
        r_tx_data <= {r_tx_data[31:0], 8'h00};
        r_tx_idx  <= r_tx_idx + 3'd1;
      end else begin
        r_tx_data <= r_tx_data;
        r_tx_idx  <= r_tx_idx;
      end
      if ((r_tx_state == ST_DATA) && w_tx_end) begin
        r_tx_bit <= r_tx_bit + 3'd1;
      end else if (r_tx_state != ST_DATA) begin
        r_tx_bit <= 3'd0;
      end else begin
        r_tx_bit <= r_tx_bit;
      end
    end
  end

  // Registered line driver and busy flag; both follow the state one edge
  // later, so the start bit and rsp_busy appear on the edge after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs232_tx <= 1'b1;
      rsp_busy <= 1'b0;
    end else begin
      rsp_busy <= (r_tx_state != ST_IDLE);
      case (r_tx_state)
        ST_IDLE:  rs232_tx <= 1'b1;
        ST_START: rs232_tx <= 1'b0;
        ST_DATA:  rs232_tx <= w_tx_cur[r_tx_bit];
        ST_STOP:  rs232_tx <= 1'b1;
        default:  rs232_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_power_uart_resp.sv
// tb_power_uart_resp
//   Directed self-checking bench for power_uart_resp. The DUT runs with a
//   short bit period (16 clocks, mid sample 7, gap limit 176 = 11 bits) so
//   every scenario of the real 24000-baud link fits in a short run.
module tb_power_uart_resp;

  localparam int BPS  = 15;
  localparam int MID  = 7;
  localparam int GAP  = 176;
  localparam int BIT  = BPS + 1;
  localparam int RSPC = 5 * 10 * BIT;   // rsp_busy high time for one frame

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rs232_rx;
  logic        rs232_tx;
  logic [31:0] cmd_data;
  logic        cmd_vld;
  logic        rsp_en;
  logic [39:0] rsp_data;
  logic        rsp_busy;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  power_uart_resp #(
    .BPS_PARA   (BPS),
    .BPS_PARA_2 (MID),
    .WAIT_TIME  (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .rs232_tx  (rs232_tx),
    .cmd_data  (cmd_data),
    .cmd_vld   (cmd_vld),
    .rsp_en    (rsp_en),
    .rsp_data  (rsp_data),
    .rsp_busy  (rsp_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts cmd_vld and frame_err cycles.
  always @(negedge clk) begin
    if (cmd_vld === 1'b1)   vld_cnt <= vld_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  // Host-side 8N1 byte driver; called and returns on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rs232_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rs232_rx = stop_v;
    repeat (BIT) @(negedge clk);
    rs232_rx = 1'b1;
  endtask

  task automatic send_cmd(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rs232_rx = 1'b1; rsp_en = 1'b0; rsp_data = 40'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rs232_tx !== 1'b1)   begin n_bad++; $display("FAIL reset_tx: got %b expected 1", rs232_tx); end
    n_cmp++; if (cmd_data !== 32'h0)  begin n_bad++; $display("FAIL reset_cmd_data: got %h expected 00000000", cmd_data); end
    n_cmp++; if (cmd_vld !== 1'b0)    begin n_bad++; $display("FAIL reset_cmd_vld: got %b expected 0", cmd_vld); end
    n_cmp++; if (rsp_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_rsp_busy: got %b expected 0", rsp_busy); end
    n_cmp++; if (frame_err !== 1'b0)  begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_cmd_frame;
    int v0 = vld_cnt, e0 = err_cnt;
    send_cmd(32'h12345678);
    repeat (20) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL cmd_vld_count: got %0d expected 1", vld_cnt - v0); end
    n_cmp++; if (cmd_data !== 32'h12345678) begin n_bad++; $display("FAIL cmd_data: got %h expected 12345678", cmd_data); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL cmd_frame_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_gap_discard;
    int v0 = vld_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    repeat (300) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 0) begin n_bad++; $display("FAIL gap_no_vld: got %0d expected 0", vld_cnt - v0); end
    send_cmd(32'h01020304);
    repeat (20) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL gap_vld_count: got %0d expected 1", vld_cnt - v0); end
    n_cmp++; if (cmd_data !== 32'h01020304) begin n_bad++; $display("FAIL gap_cmd_data: got %h expected 01020304", cmd_data); end
  endtask

  // A pause well inside the gap limit must keep the partial frame.
  task automatic test_gap_keep;
    int v0 = vld_cnt;
    send_byte(8'hC0, 1'b1);
    send_byte(8'hDE, 1'b1);
    repeat (120) @(negedge clk);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL gap_keep_vld: got %0d expected 1", vld_cnt - v0); end
    n_cmp++; if (cmd_data !== 32'hC0DE1234) begin n_bad++; $display("FAIL gap_keep_data: got %h expected c0de1234", cmd_data); end
  endtask

  task automatic test_frame_err;
    int v0 = vld_cnt, e0 = err_cnt;
    send_byte(8'h11, 1'b1);   // partial frame that the error must drop
    send_byte(8'h55, 1'b0);   // stop bit forced low
    repeat (20) @(negedge clk);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d expected 1", err_cnt - e0); end
    send_cmd(32'hDEADBEEF);
    repeat (20) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL ferr_vld: got %0d expected 1", vld_cnt - v0); end
    n_cmp++; if (cmd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ferr_cmd_data: got %h expected deadbeef", cmd_data); end
  endtask

  task automatic test_glitch;
    int v0 = vld_cnt, e0 = err_cnt;
    rs232_rx = 1'b0;
    repeat (4) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 0) begin n_bad++; $display("FAIL glitch_vld: got %0d expected 0", vld_cnt - v0); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
    send_cmd(32'hCAFEF00D);
    repeat (20) @(negedge clk);
    n_cmp++; if (cmd_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL glitch_after_data: got %h expected cafef00d", cmd_data); end
  endtask

  task automatic test_response;
    logic [7:0] dec [5];
    logic       stp [5];
    logic [7:0] exp_b [5];
    int  busy_cyc = 0;
    bit  tmo = 1'b0;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'h0F; exp_b[3] = 8'hF0; exp_b[4] = 8'h01;
    for (int i = 0; i < 5; i++) begin dec[i] = 8'h00; stp[i] = 1'b0; end
    rsp_data = 40'hA55A0FF001;
    rsp_en   = 1'b1;
    fork
      begin
        @(negedge clk);
        rsp_en   = 1'b0;
        rsp_data = 40'hFFFFFFFFFF;
        repeat (300) @(negedge clk);
        rsp_data = 40'h1122334455;
        rsp_en   = 1'b1;
        @(negedge clk);
        rsp_en   = 1'b0;
      end
      begin
        for (int w = 0; w < 100 && rsp_busy !== 1'b1; w++) @(negedge clk);
        while (rsp_busy === 1'b1 && busy_cyc < 4 * RSPC) begin
          busy_cyc++;
          @(negedge clk);
        end
      end
      begin
        for (int b = 0; b < 5; b++) begin
          int w = 0;
          while (rs232_tx !== 1'b0 && w < 2000) begin w++; @(negedge clk); end
          if (w >= 2000) tmo = 1'b1;
          repeat (BIT / 2) @(negedge clk);
          for (int k = 0; k < 8; k++) begin
            repeat (BIT) @(negedge clk);
            dec[b][k] = rs232_tx;
          end
          repeat (BIT) @(negedge clk);
          stp[b] = rs232_tx;
        end
      end
    join
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL rsp_timeout: got %b expected 0", tmo); end
    for (int b = 0; b < 5; b++) begin
      n_cmp++; if (dec[b] !== exp_b[b]) begin n_bad++; $display("FAIL rsp_byte%0d: got %h expected %h", b, dec[b], exp_b[b]); end
      n_cmp++; if (stp[b] !== 1'b1) begin n_bad++; $display("FAIL rsp_stop%0d: got %b expected 1", b, stp[b]); end
    end
    n_cmp++; if (busy_cyc !== RSPC) begin n_bad++; $display("FAIL rsp_busy_len: got %0d expected %0d", busy_cyc, RSPC); end
    repeat (50) @(negedge clk);
    n_cmp++; if (rsp_busy !== 1'b0) begin n_bad++; $display("FAIL rsp_ignored_busy: got %b expected 0", rsp_busy); end
    n_cmp++; if (rs232_tx !== 1'b1) begin n_bad++; $display("FAIL rsp_ignored_tx: got %b expected 1", rs232_tx); end
  endtask

  // rsp_en held through the end of a frame is taken on the cycle rsp_busy
  // falls, giving exactly one idle cycle between the two frames.
  task automatic test_back_to_back;
    int c1 = 0, c2 = 0;
    rsp_data = 40'h1122334455;
    rsp_en   = 1'b1;
    for (int w = 0; w < 100 && rsp_busy !== 1'b1; w++) @(negedge clk);
    while (rsp_busy === 1'b1 && c1 < 4 * RSPC) begin c1++; @(negedge clk); end
    rsp_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got %b expected 1", rsp_busy); end
    while (rsp_busy === 1'b1 && c2 < 4 * RSPC) begin c2++; @(negedge clk); end
    n_cmp++; if (c1 !== RSPC) begin n_bad++; $display("FAIL b2b_len1: got %0d expected %0d", c1, RSPC); end
    n_cmp++; if (c2 !== RSPC) begin n_bad++; $display("FAIL b2b_len2: got %0d expected %0d", c2, RSPC); end
    repeat (20) @(negedge clk);
  endtask

  // Reset lands inside TX byte 3 (cycles 320..480) and RX byte 2.
  task automatic test_reset_midflight;
    int v0 = vld_cnt, e0 = err_cnt;
    rsp_data = 40'h0102030405;
    rsp_en   = 1'b1;
    @(negedge clk);
    rsp_en = 1'b0;
    repeat (158) @(negedge clk);
    send_byte(8'h3C, 1'b1);
    rs232_rx = 1'b0;                 // byte 0xFF: start bit, then data high
    repeat (BIT) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    n_cmp++; if (rsp_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_busy: got %b expected 1", rsp_busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (rs232_tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx: got %b expected 1", rs232_tx); end
    n_cmp++; if (rsp_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", rsp_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (cmd_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_cmd_data: got %h expected 00000000", cmd_data); end
    repeat (300) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 0) begin n_bad++; $display("FAIL rstmid_no_vld: got %0d expected 0", vld_cnt - v0); end
    n_cmp++; if (rsp_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_busy: got %b expected 0", rsp_busy); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL rstmid_err: got %0d expected 0", err_cnt - e0); end
    send_cmd(32'h0BADF00D);
    repeat (20) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL rstmid_vld: got %0d expected 1", vld_cnt - v0); end
    n_cmp++; if (cmd_data !== 32'h0BADF00D) begin n_bad++; $display("FAIL rstmid_data: got %h expected 0badf00d", cmd_data); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_cmd_frame;
    test_gap_discard;
    test_gap_keep;
    test_frame_err;
    test_glitch;
    test_response;
    test_back_to_back;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
